obuf_ld_sequencer: RTL and testbench
====================================

# obuf_ld_sequencer

Sequences DDR-to-output-buffer load transfers. Accepts DDR read beats over a valid/ready handshake, reorders each beat from the DDR interleaved lane layout into per-bank order, and serializes it into RATIO consecutive bank-write cycles to all NUM_BANKS obuf banks at an incrementing common address. It sits between the DDR read-data channel and the obuf bank write ports. It is started by the obuf load controller with a base address and beat count.

## Interface

Parameters:
- DDR_BANDWIDTH, 512, DDR beat width in bits
- NUM_BANKS, 8, number of obuf banks
- DATA_WIDTH, 8, bank word width in bits
- RATIO, DDR_BANDWIDTH/(NUM_BANKS*DATA_WIDTH), words per bank per beat; must be an integer ≥1
- ADDR_WIDTH, 10, bank address width
- BEAT_CNT_WIDTH, 16, width of the beat-count config

Ports:
- clk  in  1  sole clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_start  in  1  single-cycle start pulse; honoured only in IDLE
- cfg_base_addr  in  ADDR_WIDTH  first bank write address; latched on an accepted start
- cfg_num_beats  in  BEAT_CNT_WIDTH  DDR beats to load; latched on an accepted start
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle completion pulse
- ddr_rdata  in  DDR_BANDWIDTH  DDR beat
- ddr_rvalid  in  1  beat valid
- ddr_rready  out  1  beat accept; a transfer occurs when ddr_rvalid and ddr_rready are both high at a rising edge
- bank_wr_en  out  NUM_BANKS  per-bank write enable; all bits identical
- bank_wr_addr  out  ADDR_WIDTH  common bank write address
- bank_wr_data  out  NUM_BANKS*DATA_WIDTH  bank j data at bits [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH]

## Operation

- States:
  - IDLE: no activity.
  - STREAM: accepting beats and writing.
  - DONE: one cycle with done high.
- IDLE→STREAM on cfg_start. Latch the config, clear the beat and write counters, and mark the hold register empty.
- IDLE→DONE on cfg_start with cfg_num_beats==0.
- STREAM→DONE after the write cycle of the final slot of the final beat.
- DONE→IDLE unconditionally. cfg_start during STREAM or DONE is ignored.
- Hold register: one beat, plus a valid flag and a slot counter k in 0..RATIO-1.
- Reorder rule: DDR lane n = i*NUM_BANKS + j (DATA_WIDTH bits, lane 0 at the LSBs) becomes bank j, slot i.
- While the hold register is valid, every cycle is a write cycle:
  - bank_wr_en is all ones.
  - Bank j data is slot k of bank j.
  - bank_wr_addr = base + write count, modulo 2^ADDR_WIDTH, so the address wraps silently.
  - k increments; after slot RATIO-1 the hold register empties unless a new beat loads in the same edge.
- ddr_rready = (state==STREAM) && (beats accepted < num_beats) && (hold register empty || k==RATIO-1). Back-to-back beats therefore produce writes with no bubbles.
- ddr_rready is low once num_beats beats have been accepted. Further ddr_rvalid is ignored.
- Outputs are a function of registered state only. bank_wr_data may carry stale data when bank_wr_en is 0.

## Timing

- Reset values: busy=0, done=0, ddr_rready=0, bank_wr_en=0, bank_wr_addr=0, bank_wr_data=0, state=IDLE.
- Reset asserted mid-transfer aborts immediately: writes stop, no done pulse, all state cleared.
- Start accepted at edge E: busy and ddr_rready are high in cycle E+1.
- Beat handshake at edge H: slot 0 is written in cycle H+1 and slot RATIO-1 in cycle H+RATIO.
- Last write in cycle W: done=1 and busy=1 in cycle W+1; busy=0 in cycle W+2.
- num_beats==0: start at E gives done in cycle E+1 with no writes.
- Latency from handshake to first write is 1 cycle. Throughput is 1 bank write per cycle, i.e. one beat per RATIO cycles.

## Test plan

- Single beat, base=0x010, lane n = n (defaults):
  - Cycle 1 after the handshake writes bank j = j at address 0x010.
  - Cycle 8 writes bank j = 56+j at address 0x017.
  - done comes one cycle after the cycle-8 write.
- 4 beats with ddr_rvalid held high: exactly 32 contiguous write cycles at addresses base..base+31 with no gap. ddr_rready pulses once per 8 cycles and drops after the 4th beat.
- Random ddr_rvalid gaps over 3 beats: write data and addresses match the reorder model, bank_wr_en is 0 during starvation, and the total write count is 24.
- cfg_num_beats=0: done one cycle after start, no bank_wr_en, ddr_rready never high.
- base=0x3FC, 1 beat: addresses 0x3FC,0x3FD,0x3FE,0x3FF,0x000..0x003.
- reset_n low mid-beat, then a new start during busy: all outputs go to 0 immediately. A start while busy is ignored and the latched config is unchanged.

Source files
------------

// File: rtl/obuf_ld_sequencer.sv
// Streams DDR read beats into the obuf banks: each beat is split into RATIO slots and
// written to all banks over RATIO consecutive cycles at an incrementing common address.
module obuf_ld_sequencer #(
    parameter int unsigned DDR_BANDWIDTH  = 512,
    parameter int unsigned NUM_BANKS      = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned RATIO          = DDR_BANDWIDTH / (NUM_BANKS * DATA_WIDTH),
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned BEAT_CNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            cfg_start,
    input  logic [ADDR_WIDTH-1:0]           cfg_base_addr,
    input  logic [BEAT_CNT_WIDTH-1:0]       cfg_num_beats,
    output logic                            busy,
    output logic                            done,
    input  logic [DDR_BANDWIDTH-1:0]        ddr_rdata,
    input  logic                            ddr_rvalid,
    output logic                            ddr_rready,
    output logic [NUM_BANKS-1:0]            bank_wr_en,
    output logic [ADDR_WIDTH-1:0]           bank_wr_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_wr_data
);

    localparam int unsigned SLOT_W = NUM_BANKS * DATA_WIDTH;
    localparam int unsigned K_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(RATIO - 1);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_t;

    state_t                    r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]     r_base, w_base_nxt;
    logic [BEAT_CNT_WIDTH-1:0] r_num_beats, w_num_beats_nxt;
    logic [BEAT_CNT_WIDTH-1:0] r_beats_acc, w_beats_acc_nxt;
    logic [ADDR_WIDTH-1:0]     r_wr_cnt, w_wr_cnt_nxt;
    logic [DDR_BANDWIDTH-1:0]  r_hold, w_hold_nxt;
    logic                      r_hold_vld, w_hold_vld_nxt;
    logic [K_W-1:0]            r_k, w_k_nxt;

    logic                      w_rready;
    logic                      w_accept;
    logic                      w_slot_last;

    // Lane i*NUM_BANKS+j maps to bank j of slot i, so each slot is one contiguous chunk.
    logic [RATIO-1:0][SLOT_W-1:0] w_slots;

    assign w_slot_last = r_hold_vld && (r_k == K_LAST);
    assign w_rready    = (r_state == StStream) && (r_beats_acc < r_num_beats) &&
                         (!r_hold_vld || (r_k == K_LAST));
    assign w_accept    = w_rready && ddr_rvalid;

    always_comb begin
        w_state_nxt     = r_state;
        w_base_nxt      = r_base;
        w_num_beats_nxt = r_num_beats;
        w_beats_acc_nxt = r_beats_acc;
        w_wr_cnt_nxt    = r_wr_cnt;
        w_hold_nxt      = r_hold;
        w_hold_vld_nxt  = r_hold_vld;
        w_k_nxt         = r_k;
        unique case (r_state)
            StIdle: begin
                if (cfg_start) begin
                    w_base_nxt      = cfg_base_addr;
                    w_num_beats_nxt = cfg_num_beats;
                    w_beats_acc_nxt = '0;
                    w_wr_cnt_nxt    = '0;
                    w_hold_vld_nxt  = 1'b0;
                    w_k_nxt         = '0;
                    w_state_nxt     = (cfg_num_beats == '0) ? StDone : StStream;
                end
            end
            StStream: begin
                if (r_hold_vld) begin
                    w_wr_cnt_nxt = r_wr_cnt + 1'b1;
                    if (r_k == K_LAST) begin
                        w_hold_vld_nxt = 1'b0;
                        w_k_nxt        = '0;
                    end else begin
                        w_k_nxt = r_k + 1'b1;
                    end
                end
                // A beat landing on the last slot refills the hold register without a bubble.
                if (w_accept) begin
                    w_hold_nxt      = ddr_rdata;
                    w_hold_vld_nxt  = 1'b1;
                    w_k_nxt         = '0;
                    w_beats_acc_nxt = r_beats_acc + 1'b1;
                end
                if (w_slot_last && (r_beats_acc == r_num_beats)) begin
                    w_state_nxt = StDone;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_base      <= '0;
            r_num_beats <= '0;
            r_beats_acc <= '0;
            r_wr_cnt    <= '0;
            r_hold      <= '0;
            r_hold_vld  <= 1'b0;
            r_k         <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_base      <= w_base_nxt;
            r_num_beats <= w_num_beats_nxt;
            r_beats_acc <= w_beats_acc_nxt;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_vld  <= w_hold_vld_nxt;
            r_k         <= w_k_nxt;
        end
    end

    assign w_slots      = r_hold;
    assign busy         = (r_state != StIdle);
    assign done         = (r_state == StDone);
    assign ddr_rready   = w_rready;
    assign bank_wr_en   = {NUM_BANKS{r_hold_vld}};
    assign bank_wr_addr = r_base + r_wr_cnt;
    assign bank_wr_data = w_slots[r_k];

endmodule

// File: tb/tb_obuf_ld_sequencer.sv
// Randomized bench for obuf_ld_sequencer: a queue-based model of expected bank writes is
// compared against the DUT every cycle, plus literal expectations for directed cases.
module tb_obuf_ld_sequencer;

    localparam int DDR   = 512;
    localparam int NB    = 8;
    localparam int DW    = 8;
    localparam int RATIO = DDR / (NB * DW);
    localparam int AW    = 10;
    localparam int BW    = 16;
    localparam int SW    = NB * DW;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           cfg_start;
    logic [AW-1:0]  cfg_base_addr;
    logic [BW-1:0]  cfg_num_beats;
    logic           busy;
    logic           done;
    logic [DDR-1:0] ddr_rdata;
    logic           ddr_rvalid;
    logic           ddr_rready;
    logic [NB-1:0]  bank_wr_en;
    logic [AW-1:0]  bank_wr_addr;
    logic [SW-1:0]  bank_wr_data;

    obuf_ld_sequencer #(
        .DDR_BANDWIDTH (DDR),
        .NUM_BANKS     (NB),
        .DATA_WIDTH    (DW),
        .RATIO         (RATIO),
        .ADDR_WIDTH    (AW),
        .BEAT_CNT_WIDTH(BW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_start    (cfg_start),
        .cfg_base_addr(cfg_base_addr),
        .cfg_num_beats(cfg_num_beats),
        .busy         (busy),
        .done         (done),
        .ddr_rdata    (ddr_rdata),
        .ddr_rvalid   (ddr_rvalid),
        .ddr_rready   (ddr_rready),
        .bank_wr_en   (bank_wr_en),
        .bank_wr_addr (bank_wr_addr),
        .bank_wr_data (bank_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [SW-1:0] data;
    } wr_t;

    // Model: 0 idle, 1 streaming, 2 done cycle; q holds writes still owed, head = this cycle.
    wr_t           q[$];
    int            m_state = 0;
    logic [AW-1:0] m_base  = '0;
    logic [AW-1:0] m_wcnt  = '0;
    int            m_num   = 0;
    int            m_acc   = 0;

    int checks = 0;
    int errors = 0;
    int cnt_wr, cnt_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_rready();
        return (m_state == 1) && (m_acc < m_num) && (q.size() <= 1);
    endfunction

    function automatic logic [DDR-1:0] rand_beat();
        logic [DDR-1:0] v;
        for (int w = 0; w < DDR / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic push_beat(input logic [DDR-1:0] beat);
        wr_t w;
        for (int i = 0; i < RATIO; i++) begin
            w.addr = m_base + m_wcnt;
            m_wcnt = m_wcnt + 1'b1;
            for (int j = 0; j < NB; j++) w.data[j*DW +: DW] = beat[(i*NB + j)*DW +: DW];
            q.push_back(w);
        end
        m_acc++;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_base  = '0;
        m_wcnt  = '0;
        m_num   = 0;
        m_acc   = 0;
        q.delete();
    endtask

    // Predict the effect of the coming rising edge from the inputs now being driven.
    task automatic model_edge();
        bit hs, last;
        if (!reset_n) begin
            model_reset();
            return;
        end
        case (m_state)
            0: if (cfg_start) begin
                m_base  = cfg_base_addr;
                m_num   = int'(cfg_num_beats);
                m_acc   = 0;
                m_wcnt  = '0;
                q.delete();
                m_state = (cfg_num_beats == 0) ? 2 : 1;
            end
            1: begin
                hs   = ddr_rvalid && m_rready();
                last = (q.size() == 1) && (m_acc == m_num);
                if (q.size() > 0) q.delete(0);
                if (hs) push_beat(ddr_rdata);
                if (last) m_state = 2;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic check_cycle();
        logic [NB-1:0] en_exp;
        en_exp = (q.size() > 0) ? {NB{1'b1}} : '0;
        chk("busy", 64'(busy), 64'(m_state != 0));
        chk("done", 64'(done), 64'(m_state == 2));
        chk("rready", 64'(ddr_rready), 64'(m_rready()));
        chk("wr_en", 64'(bank_wr_en), 64'(en_exp));
        if (q.size() > 0) begin
            chk("wr_addr", 64'(bank_wr_addr), 64'(q[0].addr));
            chk("wr_data", bank_wr_data, q[0].data);
        end
        cnt_wr  += (bank_wr_en != '0) ? 1 : 0;
        cnt_rdy += ddr_rready ? 1 : 0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic start(input logic [AW-1:0] base, input int num);
        cnt_wr        = 0;
        cnt_rdy       = 0;
        cfg_base_addr = base;
        cfg_num_beats = BW'(num);
        cfg_start     = 1'b1;
        tick();
        cfg_start     = 1'b0;
    endtask

    // mode 0: ddr_rvalid held high; mode 1: random gaps.
    task automatic run(input int mode, input int budget);
        int n = 0;
        while (m_state != 0 && n < budget) begin
            ddr_rvalid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ddr_rdata  = rand_beat();
            tick();
            n++;
        end
        ddr_rvalid = 1'b0;
        if (m_state != 0) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DDR-1:0] lanes;
        reset_n       = 1'b0;
        cfg_start     = 1'b0;
        cfg_base_addr = '0;
        cfg_num_beats = '0;
        ddr_rdata     = '0;
        ddr_rvalid    = 1'b0;
        cnt_wr        = 0;
        cnt_rdy       = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rready", 64'(ddr_rready), 64'd0);
        chk("rst_wr_en", 64'(bank_wr_en), 64'd0);
        chk("rst_addr", 64'(bank_wr_addr), 64'd0);
        chk("rst_data", bank_wr_data, 64'd0);
        reset_n = 1'b1;

        // Single beat, lane n holds n.
        start(10'h010, 1);
        chk("t1_rready", 64'(ddr_rready), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        for (int n = 0; n < DDR / DW; n++) lanes[n*DW +: DW] = DW'(n);
        ddr_rdata  = lanes;
        ddr_rvalid = 1'b1;
        tick();
        ddr_rvalid = 1'b0;
        chk("t1_first_data", bank_wr_data, 64'h0706050403020100);
        chk("t1_first_addr", 64'(bank_wr_addr), 64'h010);
        repeat (7) tick();
        chk("t1_last_data", bank_wr_data, 64'h3F3E3D3C3B3A3938);
        chk("t1_last_addr", 64'(bank_wr_addr), 64'h017);
        tick();
        chk("t1_done", 64'(done), 64'd1);
        tick();
        chk("t1_idle", 64'(busy), 64'd0);

        // Four back-to-back beats.
        start(AW'($urandom_range(0, 1023)), 4);
        run(0, 200);
        chk("t2_writes", 64'(cnt_wr), 64'd32);
        chk("t2_rready_cycles", 64'(cnt_rdy), 64'd4);

        // Three beats with random valid gaps, repeated.
        for (int r = 0; r < 4; r++) begin
            start(AW'($urandom_range(0, 1023)), 3);
            run(1, 600);
            chk("t3_writes", 64'(cnt_wr), 64'd24);
        end

        // Zero beats.
        start(10'h055, 0);
        chk("t4_done", 64'(done), 64'd1);
        tick();
        chk("t4_idle", 64'(busy), 64'd0);
        chk("t4_writes", 64'(cnt_wr), 64'd0);
        chk("t4_rready", 64'(cnt_rdy), 64'd0);

        // Address wrap.
        start(10'h3FC, 1);
        ddr_rdata  = rand_beat();
        ddr_rvalid = 1'b1;
        tick();
        ddr_rvalid = 1'b0;
        chk("t5_addr0", 64'(bank_wr_addr), 64'h3FC);
        repeat (4) tick();
        chk("t5_addr4", 64'(bank_wr_addr), 64'h000);
        run(0, 50);
        chk("t5_writes", 64'(cnt_wr), 64'd8);

        // Reset mid-beat, then a start while busy must be ignored.
        start(10'h080, 2);
        ddr_rdata  = rand_beat();
        ddr_rvalid = 1'b1;
        tick();
        ddr_rvalid = 1'b0;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_wr_en", 64'(bank_wr_en), 64'd0);
        chk("t6_rst_rready", 64'(ddr_rready), 64'd0);
        chk("t6_rst_addr", 64'(bank_wr_addr), 64'd0);
        chk("t6_rst_data", bank_wr_data, 64'd0);
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        start(10'h100, 2);
        cfg_base_addr = 10'h200;
        cfg_num_beats = 16'd5;
        cfg_start     = 1'b1;
        tick();
        cfg_start     = 1'b0;
        run(1, 400);
        chk("t6_writes", 64'(cnt_wr), 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
